fp_mul_round: RTL and testbench

//  Pipelined signed fixed-point multiplier with rounding right-shift and valid/ready flow control.

---
 rtl/fp_mul_round.sv | 89 ++++++++
 tb/tb_fp_mul_round.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_round.sv
// Two-stage signed fixed-point multiplier with rounding right-shift and valid/ready flow control.
// Define FP_MUL_CONVERGENT_ROUND_EN for round-half-to-even; default build rounds half-up.
module fp_mul_round #(
    parameter  int AW   = 16,
    parameter  int BW   = 16,
    parameter  int FRAC = 8,
    localparam int OW   = AW + BW - FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [AW-1:0] in_a,
    input  logic signed [BW-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_p,
    output logic                 out_last
);

    localparam int PW = AW + BW;

    logic                 v1, v2;
    logic                 t1, t2;
    logic                 adv1, adv2;
    logic signed [PW-1:0] p1;
    logic signed [OW-1:0] r2;
    logic signed [OW-1:0] rnd;

    always_comb begin
        adv2     = !v2 || out_ready;
        adv1     = !v1 || adv2;
        in_ready = adv1 && !rst;
    end

    generate
        if (FRAC == 0) begin : g_norm
            always_comb rnd = p1;
        end else begin : g_rnd
            localparam logic [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (FRAC - 1);
            logic [PW:0] bias;
            logic [PW:0] sum;
            always_comb begin
`ifdef FP_MUL_CONVERGENT_ROUND_EN
                // HALF-1 plus the surviving LSB: an exact tie carries only when the quotient is odd
                bias = HALF - {{PW{1'b0}}, 1'b1} + {{PW{1'b0}}, p1[FRAC]};
`else
                bias = HALF;
`endif
                sum = {p1[PW-1], p1} + bias;
                rnd = sum[FRAC +: OW];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            p1 <= '0;
            r2 <= '0;
            t1 <= 1'b0;
            t2 <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    p1 <= in_a * in_b;
                    t1 <= in_last;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    r2 <= rnd;
                    t2 <= t1;
                end
            end
        end
    end

    always_comb begin
        out_valid = v2;
        out_p     = r2;
        out_last  = t2;
    end

endmodule

// File: tb/tb_fp_mul_round.sv
// Directed and randomised checks of fp_mul_round at AW=BW=16, FRAC=8 (OW=24).
module tb_fp_mul_round;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [15:0]         in_a;
    logic [15:0]         in_b;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [23:0]  out_p;
    logic                out_last;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [24:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [23:0] held_p = '0;

    always #5 clk = ~clk;

    fp_mul_round #(.AW(16), .BW(16), .FRAC(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_last(out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [15:0] a, input logic [15:0] b);
        longint p, q, rem;
        p   = longint'($signed(a)) * longint'($signed(b));
        q   = p >>> 8;
        rem = p - (q <<< 8);
        if (rem > 128) q = q + 1;
        else if (rem == 128) begin
`ifdef FP_MUL_CONVERGENT_ROUND_EN
            if (q[0]) q = q + 1;
`else
            q = q + 1;
`endif
        end
        return q[23:0];
    endfunction

    // One clock: evaluate handshakes mid-cycle, score them, then move to the next falling edge.
    task automatic run_cycle();
        logic [24:0] e;
        #1;
        if (stall_prev) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_p", {8'h0, out_p}, {8'h0, held_p});
        end
        if (in_valid && in_ready) exp_q.push_back({in_last, model(in_a, in_b)});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("stream_p", {8'h0, out_p}, {8'h0, e[23:0]});
                check("stream_last", {31'b0, out_last}, {31'b0, e[24]});
            end
        end
        stall_prev = out_valid && !out_ready;
        held_p     = out_p;
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic last, input logic [23:0] exp_p);
        bit seen = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        out_ready = 1'b1;
        run_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            #1;
            if (out_valid) begin
                check(tag, {8'h0, out_p}, {8'h0, exp_p});
                check({tag, "_last"}, {31'b0, out_last}, {31'b0, last});
                seen = 1;
            end
            run_cycle();
        end
        if (!seen) check({tag, "_timeout"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned accepted;
        int unsigned cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_p", {8'h0, out_p}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latency: one cycle after accept nothing yet, two cycles after accept the result.
        in_valid = 1'b1; in_a = 16'h0180; in_b = 16'h0100; in_last = 1'b1;
        #1;
        check("lat_in_ready", {31'b0, in_ready}, 32'd1);
        run_cycle();
        in_valid = 1'b0;
        #1;
        check("lat1_notyet", {31'b0, out_valid}, 32'd0);
        run_cycle();
        #1;
        check("lat2_valid", {31'b0, out_valid}, 32'd1);
        check("lat2_p", {8'h0, out_p}, 32'h000180);
        check("lat2_last", {31'b0, out_last}, 32'd1);
        run_cycle();

        // Rounding boundaries.
`ifdef FP_MUL_CONVERGENT_ROUND_EN
        directed("tie_2p5", 16'h0005, 16'h0080, 1'b0, 24'h000002);
        directed("tie_m1p5", 16'hFFFD, 16'h0080, 1'b1, 24'hFFFFFE);
`else
        directed("tie_2p5", 16'h0005, 16'h0080, 1'b0, 24'h000003);
        directed("tie_m1p5", 16'hFFFD, 16'h0080, 1'b1, 24'hFFFFFF);
`endif
        directed("tie_m0p5", 16'hFFFF, 16'h0080, 1'b0, 24'h000000);
        directed("tie_1p5", 16'h0003, 16'h0080, 1'b1, 24'h000002);
        directed("above_half", 16'h0001, 16'h0081, 1'b0, 24'h000001);
        directed("below_half", 16'h0001, 16'h007F, 1'b1, 24'h000000);
        directed("max_neg_sq", 16'h8000, 16'h8000, 1'b0, 24'h400000);
        directed("max_by_neg", 16'h7FFF, 16'h8000, 1'b1, 24'hC00080);

        // Fill both stages with the output blocked, then drain back-to-back.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_a = 16'h0200; in_b = 16'h0300; in_last = 1'b0;
        run_cycle();
        in_a = 16'hFE00; in_b = 16'h0100; in_last = 1'b1;
        #1;
        check("fill_in_ready2", {31'b0, in_ready}, 32'd1);
        run_cycle();
        in_a = 16'h1111; in_b = 16'h2222;
        #1;
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        run_cycle();
        run_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("unblock_in_ready", {31'b0, in_ready}, 32'd1);
        check("drain1_p", {8'h0, out_p}, 32'h000600);
        run_cycle();
        #1;
        check("drain2_valid", {31'b0, out_valid}, 32'd1);
        check("drain2_p", {8'h0, out_p}, 32'hFFFE00);
        run_cycle();
        #1;
        check("drain_done", {31'b0, out_valid}, 32'd0);
        run_cycle();

        // Random traffic with random back-pressure.
        accepted = 0;
        cyc      = 0;
        while (accepted < 100 && cyc < 2000) begin
            in_valid  = $urandom_range(1, 0) == 1;
            out_ready = $urandom_range(1, 0) == 1;
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_last   = 1'($urandom);
            #1;
            if (in_valid && in_ready) accepted++;
            run_cycle();
            cyc++;
        end
        check("rand_accepted", accepted, 32'd100);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) run_cycle();
        check("rand_drained", exp_q.size(), 32'd0);

        // Reset with two items in flight discards both.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_a = 16'h0400; in_b = 16'h0400; in_last = 1'b1;
        run_cycle();
        run_cycle();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_p", {8'h0, out_p}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (6) run_cycle();
        check("post_rst_idle", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
